// File: rtl/serializer_feeder_pkg.sv
// Shared constants for the serializer feeder: launch FSM encoding and watchdog length.
package serializer_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } feeder_state_t;

  localparam logic [1:0] WDOG_LEN = 2'd2;

endpackage

// File: rtl/serializer_feeder_fifo.sv
// Synchronous FIFO with registered occupancy; full/empty decode from the count.
module serializer_feeder_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int COUNT_WIDTH = ADDR_WIDTH + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  push_data,
  input  logic                   pop,
  output logic [DATA_WIDTH-1:0]  head,
  output logic                   full,
  output logic                   empty,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == COUNT_WIDTH'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at ADDR_WIDTH bits since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serializer_feeder.sv
// Buffers producer words and launches them one at a time into an LSB-first serializer.
//   state      | meaning
//   ST_IDLE    | nothing in flight; launch when FIFO non-empty and serializer idle
//   ST_LAUNCH  | ser_start high for this single cycle
//   ST_WAIT_HI | waiting for serializer busy, watchdog running
//   ST_WAIT_LO | frame in progress; chain next launch when busy drops
module serializer_feeder
  import serializer_feeder_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int COUNT_WIDTH = ADDR_WIDTH + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow,
  output logic                   launch_err,
  output logic                   idle,
  output logic [DATA_WIDTH-1:0]  ser_data,
  output logic                   ser_start,
  input  logic                   ser_busy
);

  feeder_state_t         state, state_nx;
  logic [1:0]            wdog, wdog_nx;
  logic [DATA_WIDTH-1:0] data_nx;
  logic [DATA_WIDTH-1:0] head;
  logic                  start_nx;
  logic                  pop;
  logic                  err_set;

  serializer_feeder_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (wr_en),
    .push_data(wr_data),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign idle = empty && (state == ST_IDLE);

  always_comb begin
    state_nx = state;
    wdog_nx  = wdog;
    data_nx  = ser_data;
    start_nx = 1'b0;
    pop      = 1'b0;
    err_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !ser_busy) begin
          state_nx = ST_LAUNCH;
          start_nx = 1'b1;
          data_nx  = head;
          pop      = 1'b1;
        end
      end
      ST_LAUNCH: begin
        state_nx = ST_WAIT_HI;
        wdog_nx  = WDOG_LEN;
      end
      ST_WAIT_HI: begin
        if (ser_busy) begin
          state_nx = ST_WAIT_LO;
        end else if (wdog == 2'd1) begin
          // Serializer never acknowledged: the word is dropped, not re-queued.
          err_set  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          wdog_nx = wdog - 2'd1;
        end
      end
      ST_WAIT_LO: begin
        if (!ser_busy) begin
          if (!empty) begin
            state_nx = ST_LAUNCH;
            start_nx = 1'b1;
            data_nx  = head;
            pop      = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      wdog       <= '0;
      ser_data   <= '0;
      ser_start  <= 1'b0;
      overflow   <= 1'b0;
      launch_err <= 1'b0;
    end else begin
      state     <= state_nx;
      wdog      <= wdog_nx;
      ser_data  <= data_nx;
      ser_start <= start_nx;
      if (wr_en && full) overflow <= 1'b1;
      if (err_set)       launch_err <= 1'b1;
    end
  end

endmodule

// File: doc/serializer_feeder.md
Name: serializer_feeder

Overview:
- Buffers parallel words from the producer logic and launches them one at a time into the downstream serializer stage.
- The serializer stage is the LSB-first, idle-high bit shifter with start/busy handshake.
- The feeder owns a small synchronous FIFO and a launch FSM.
- It drives start and data only when the serializer is idle, and never re-launches before the previous frame has completed.

Parameters:
- DATA_WIDTH, 8, word width. Must match the serializer's DATA_WIDTH.
- DEPTH, 16, FIFO depth in words. Must be a power of two, ≥2.
- ADDR_WIDTH, $clog2(DEPTH), FIFO pointer width.
- COUNT_WIDTH, ADDR_WIDTH+1, occupancy counter width (holds 0..DEPTH).

Ports:
- clock  in  1  rising-edge clock shared with the serializer
- reset  in  1  synchronous, active-low reset (asserted when 0)
- wr_data  in  DATA_WIDTH  word to enqueue
- wr_en  in  1  enqueue strobe; accepted when full==0
- full  out  1  FIFO holds DEPTH words
- empty  out  1  FIFO holds 0 words
- count  out  COUNT_WIDTH  current FIFO occupancy
- overflow  out  1  sticky: wr_en seen while full
- launch_err  out  1  sticky: serializer failed to assert busy after start
- idle  out  1  FIFO empty and FSM in IDLE (all traffic drained)
- ser_data  out  DATA_WIDTH  word presented to serializer data_in
- ser_start  out  1  one-cycle start pulse to serializer
- ser_busy  in  1  serializer busy output

Behaviour:
- Reset (reset==0 at rising edge):
  - pointers=0, count=0, overflow=0, launch_err=0, FSM=IDLE.
  - ser_start=0, ser_data=0, so full=0, empty=1, idle=1.
  - Reset mid-frame discards FIFO contents and abandons the in-flight launch; the serializer is not signalled.
- All outputs are registered, except full/empty/idle, which decode combinationally from registered count/state.
- FIFO:
  - Write when wr_en && !full.
  - wr_en && full: word dropped, overflow set to 1 until reset.
  - Pop happens only on the IDLE/WAIT_LO→LAUNCH transition edge.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LAUNCH, WAIT_HI, WAIT_LO.
  - IDLE:
    - if !empty && !ser_busy → LAUNCH; at the same edge, ser_data<=head, ser_start<=1, pop.
    - Write into an empty FIFO at edge E launches at edge E+1, so ser_start is high in the cycle after E+1.
  - LAUNCH:
    - ser_start is high for exactly this one cycle; the serializer captures ser_data at the closing edge.
    - → WAIT_HI with ser_start<=0 and a 2-cycle watchdog loaded.
  - WAIT_HI:
    - ser_busy==1 → WAIT_LO.
    - Otherwise decrement the watchdog; on expiry (2 cycles without busy), set launch_err and → IDLE. The word is lost, not re-queued.
  - WAIT_LO:
    - Hold while ser_busy==1.
    - On ser_busy==0: if !empty → LAUNCH directly (same pop/load as IDLE), else → IDLE.
- ser_data holds its last launched value outside LAUNCH. ser_start is never high in two consecutive cycles.
- Frame timing with a compliant serializer: ser_start high at cycle L → busy high L+1..L+DATA_WIDTH, low at L+DATA_WIDTH+1.
- Back-to-back throughput: one word per DATA_WIDTH+2 cycles, with exactly 2 idle-high line cycles between frames.
- ser_busy high while in IDLE (foreign/stale frame): no launch until it drops.

Decomposition:
- Shared package: the FSM state encoding constants (IDLE=2'd0, LAUNCH=2'd1, WAIT_HI=2'd2, WAIT_LO=2'd3) and the watchdog length constant (2).
- One natural sub-module: sync_fifo (parameterised DATA_WIDTH/DEPTH) with push/pop/full/empty/count. The launch FSM and sticky flags stay in serializer_feeder.

Test Plan:
- Reset with reset=0 for 3 cycles while wr_en=1, wr_data=8'hFF → count=0, empty=1, ser_start=0, overflow=0; no launch after release until a new write.
- Single word: write 8'hA5 at edge E, serializer model attached → ser_start high one cycle after E+1 with ser_data=8'hA5; serial line shows 1,0,1,0,0,1,0,1 (LSB first); idle=1 after busy falls.
- Burst: 4 writes 8'h01,8'h02,8'h03,8'h04 back-to-back → four launches in order; start-to-start spacing exactly 10 cycles (DATA_WIDTH=8); ser_start never high while ser_busy=1.
- Fill/overflow: 17 writes with serializer busy held high by the model → full=1 after 16, count=16, overflow=1 sticky; the 17th word is never emitted after busy releases.
- Simultaneous write and pop at count=1 → count stays 1, the launched word is the old head, the new word is launched next frame.
- Dead serializer: ser_busy tied 0, write 8'h3C → one ser_start pulse, launch_err=1 after 2 cycles in WAIT_HI, FSM back to IDLE, count=0.
